gf233_word_serializer: RTL

Converts one 233-bit GF(2^233) field element into a stream of 32-bit words, least-significant word first, using valid/ready handshakes on both sides. It is the transmit end of the element-to-word bus. It sits between the field-arithmetic datapath, which produces full-width elements, and the narrow word interface, where a matching packer reassembles the words into elements.

---
 rtl/gf233_word_serializer.sv | 110 +++++++++++
 1 files changed

// File: rtl/gf233_word_serializer.sv
// gf233_word_serializer
// Transmit end of the element-to-word bus: takes one M-bit GF(2^233) field
// element and emits it as NWORDS W-bit words, least-significant word first.
// The top word is zero-padded above bit M-1.
//
// Ports:
//   clk, rst   - single rising-edge clock, synchronous active-high reset
//   in_valid   - in_data holds an element to send
//   in_ready   - block can accept an element (high only in IDLE)
//   in_data    - M-bit field element, bit 0 = x^0 coefficient
//   out_valid  - out_data holds a valid word
//   out_ready  - downstream accepts the current word
//   out_data   - current W-bit word
//   out_last   - current word is the final word of the element
//   busy       - an element is being transmitted
//
// All outputs are decoded from registered state only, so nothing depends
// combinationally on in_valid or out_ready.
module gf233_word_serializer #(
    parameter int M      = 233,
    parameter int W      = 32,
    parameter int NWORDS = (M + W - 1) / W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int SW = NWORDS * W;
    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] shreg;
    logic [SW-1:0] ext_data;
    logic [IW-1:0] idx;
    logic          in_fire;
    logic          out_fire;
    logic          at_last;

    // Zero-extend the element to the full word-aligned width.
    always_comb begin
        ext_data        = '0;
        ext_data[M-1:0] = in_data;
    end

    assign in_fire  = (state == IDLE) && in_valid;
    assign out_fire = (state == SEND) && out_ready;
    assign at_last  = (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (out_ready && at_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The shift register and index only move on a handshake, so a stalled
    // word (and its last flag) holds without any extra enable logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            idx   <= '0;
        end else if (in_fire) begin
            shreg <= ext_data;
            idx   <= '0;
        end else if (out_fire && !at_last) begin
            shreg <= shreg >> W;
            idx   <= idx + 1'b1;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == SEND);
    assign busy      = (state == SEND);
    assign out_last  = (state == SEND) && at_last;
    assign out_data  = shreg[W-1:0];

endmodule
